// File: rtl/cond_flags_unit.sv
// cond_flags_unit: ARM condition check against registered NZCV flags, gated E-stage controls and execute/squash counters.
module cond_flags_unit #(
    parameter int W         = 32,
    parameter int CNT_W     = 16,
    parameter int COND_FULL = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ValidE,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [3:0]       CondE,
    input  logic [1:0]       FlagWriteE,
    input  logic [W-1:0]     ALUResult,
    input  logic             carry_out_flag,
    input  logic             overflow_flag,
    input  logic             PCSrcE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    output logic             CondExE,
    output logic             PCSrcG,
    output logic             RegWriteG,
    output logic             MemWriteG,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] exec_q, exec_d, squash_q, squash_d;
    logic             fn, fz, fc, fv, base, full_pass, cond_pass, live;
    logic             alu_n, alu_z;

    assign alu_n = ALUResult[W-1];
    assign alu_z = (ALUResult == '0);
    assign {fn, fz, fc, fv} = flags_q;

    // Codes come in true/inverted pairs: bits [3:1] pick the test, bit 0 inverts it (1111 = never).
    always_comb begin
        base = 1'b1;
        case (CondE[3:1])
            3'd0:    base = fz;
            3'd1:    base = fc;
            3'd2:    base = fn;
            3'd3:    base = fv;
            3'd4:    base = fc & ~fz;
            3'd5:    base = (fn == fv);
            3'd6:    base = ~fz & (fn == fv);
            default: base = 1'b1;
        endcase
        full_pass = base ^ CondE[0];
        cond_pass = (COND_FULL != 0) ? full_pass
                  : full_pass & (CondE == 4'b0000 || CondE == 4'b0001 || CondE == 4'b1110);
    end

    assign live      = reset_n & ValidE & ~FlushE & ~StallE;
    assign CondExE   = cond_pass & live;
    assign PCSrcG    = PCSrcE & CondExE;
    assign RegWriteG = RegWriteE & CondExE;
    assign MemWriteG = MemWriteE & CondExE;

    always_comb begin
        flags_d[3:2] = (CondExE & FlagWriteE[1]) ? {alu_n, alu_z} : flags_q[3:2];
        flags_d[1:0] = (CondExE & FlagWriteE[0]) ? {carry_out_flag, overflow_flag} : flags_q[1:0];
        exec_d       = (CondExE && exec_q != '1) ? exec_q + 1'b1 : exec_q;
        squash_d     = (live && !cond_pass && squash_q != '1) ? squash_q + 1'b1 : squash_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q  <= 4'b0000;
            exec_q   <= '0;
            squash_q <= '0;
        end else begin
            flags_q  <= flags_d;
            exec_q   <= exec_d;
            squash_q <= squash_d;
        end
    end

    assign Flags      = flags_q;
    assign exec_cnt   = exec_q;
    assign squash_cnt = squash_q;
endmodule

// File: tb/tb_cond_flags_unit.sv
// tb_cond_flags_unit: directed checks of cond_flags_unit in full, reduced-decode and 4-bit-counter configurations.
module tb_cond_flags_unit;
    logic        clk = 1'b0;
    logic        reset_n, ValidE, StallE, FlushE, carry_out_flag, overflow_flag;
    logic        PCSrcE, RegWriteE, MemWriteE;
    logic [3:0]  CondE;
    logic [1:0]  FlagWriteE;
    logic [31:0] ALUResult;
    logic        cx_f, pc_f, rw_f, mw_f, cx_m, pc_m, rw_m, mw_m, cx_s, pc_s, rw_s, mw_s;
    logic [3:0]  fl_f, fl_m, fl_s;
    logic [15:0] ex_f, sq_f, ex_m, sq_m;
    logic [3:0]  ex_s, sq_s;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    cond_flags_unit u_full (
        .clk(clk), .reset_n(reset_n), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
        .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUResult(ALUResult),
        .carry_out_flag(carry_out_flag), .overflow_flag(overflow_flag),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .CondExE(cx_f), .PCSrcG(pc_f), .RegWriteG(rw_f), .MemWriteG(mw_f),
        .Flags(fl_f), .exec_cnt(ex_f), .squash_cnt(sq_f));

    cond_flags_unit #(.COND_FULL(0)) u_min (
        .clk(clk), .reset_n(reset_n), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
        .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUResult(ALUResult),
        .carry_out_flag(carry_out_flag), .overflow_flag(overflow_flag),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .CondExE(cx_m), .PCSrcG(pc_m), .RegWriteG(rw_m), .MemWriteG(mw_m),
        .Flags(fl_m), .exec_cnt(ex_m), .squash_cnt(sq_m));

    cond_flags_unit #(.CNT_W(4)) u_sat (
        .clk(clk), .reset_n(reset_n), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
        .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUResult(ALUResult),
        .carry_out_flag(carry_out_flag), .overflow_flag(overflow_flag),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .CondExE(cx_s), .PCSrcG(pc_s), .RegWriteG(rw_s), .MemWriteG(mw_s),
        .Flags(fl_s), .exec_cnt(ex_s), .squash_cnt(sq_s));

    function automatic logic cond_ref(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (code)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic st, input logic fl, input logic [3:0] cc,
                         input logic [1:0] fw, input logic [31:0] res, input logic c, input logic o);
        ValidE = v; StallE = st; FlushE = fl; CondE = cc; FlagWriteE = fw;
        ALUResult = res; carry_out_flag = c; overflow_flag = o;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        PCSrcE = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b1;
        drive(1, 0, 0, 4'b1110, 2'b11, 32'h0, 1, 1);
        n_cmp++;
        if ({cx_f, pc_f, rw_f, mw_f} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_gating: got %b want 0000", {cx_f, pc_f, rw_f, mw_f});
        end
        tick();
        n_cmp++;
        if (fl_f !== 4'b0000 || ex_f !== 16'd0 || sq_f !== 16'd0) begin
            n_bad++; $display("FAIL reset_state: flags %b exec %0d squash %0d want 0000/0/0", fl_f, ex_f, sq_f);
        end
        reset_n = 1'b1;
        PCSrcE = 1'b0; RegWriteE = 1'b0; MemWriteE = 1'b0;
        drive(0, 0, 0, 4'b0000, 2'b00, 32'h0, 0, 0);
    endtask

    task automatic test_post_reset_cond();
        drive(1, 0, 0, 4'b0000, 2'b00, 32'h0, 0, 0);
        n_cmp++;
        if (cx_f !== 1'b0) begin n_bad++; $display("FAIL post_reset_eq: got %b want 0", cx_f); end
        drive(1, 0, 0, 4'b0001, 2'b00, 32'h0, 0, 0);
        n_cmp++;
        if (cx_f !== 1'b1) begin n_bad++; $display("FAIL post_reset_ne: got %b want 1", cx_f); end
        drive(1, 0, 0, 4'b1110, 2'b00, 32'h0, 0, 0);
        n_cmp++;
        if (cx_f !== 1'b1) begin n_bad++; $display("FAIL post_reset_al: got %b want 1", cx_f); end
        drive(0, 0, 0, 4'b0000, 2'b00, 32'h0, 0, 0);
    endtask

    task automatic test_back_to_back();
        PCSrcE = 1'b1;
        drive(1, 0, 0, 4'b1110, 2'b11, 32'h0, 1, 0);
        n_cmp++;
        if ({cx_f, pc_f} !== 2'b11) begin n_bad++; $display("FAIL cmp_exec: got %b want 11", {cx_f, pc_f}); end
        tick();
        n_cmp++;
        if (fl_f !== 4'b0110 || ex_f !== 16'd1) begin
            n_bad++; $display("FAIL cmp_flags: flags %b exec %0d want 0110/1", fl_f, ex_f);
        end
        drive(1, 0, 0, 4'b0000, 2'b00, 32'h5, 0, 1);
        n_cmp++;
        if ({cx_f, pc_f} !== 2'b11) begin n_bad++; $display("FAIL beq_taken: got %b want 11", {cx_f, pc_f}); end
        tick();
        n_cmp++;
        if (ex_f !== 16'd2 || fl_f !== 4'b0110) begin
            n_bad++; $display("FAIL beq_count: exec %0d flags %b want 2/0110", ex_f, fl_f);
        end
        PCSrcE = 1'b0;
    endtask

    task automatic test_ne_squash();
        RegWriteE = 1'b1;
        drive(1, 0, 0, 4'b0001, 2'b11, 32'h8000_0000, 0, 1);
        n_cmp++;
        if ({cx_f, rw_f} !== 2'b00) begin n_bad++; $display("FAIL ne_gate: got %b want 00", {cx_f, rw_f}); end
        tick();
        n_cmp++;
        if (sq_f !== 16'd1 || ex_f !== 16'd2 || fl_f !== 4'b0110) begin
            n_bad++; $display("FAIL ne_squash: squash %0d exec %0d flags %b want 1/2/0110", sq_f, ex_f, fl_f);
        end
        RegWriteE = 1'b0;
    endtask

    task automatic test_partial_write();
        MemWriteE = 1'b1;
        drive(1, 0, 0, 4'b1110, 2'b10, 32'h8000_0000, 0, 1);
        n_cmp++;
        if (mw_f !== 1'b1) begin n_bad++; $display("FAIL nz_memwrite: got %b want 1", mw_f); end
        tick();
        n_cmp++;
        if (fl_f !== 4'b1010) begin n_bad++; $display("FAIL nz_only: got %b want 1010", fl_f); end
        drive(1, 0, 0, 4'b1110, 2'b01, 32'h0, 0, 1);
        tick();
        n_cmp++;
        if (fl_f !== 4'b1001 || ex_f !== 16'd4) begin
            n_bad++; $display("FAIL cv_only: flags %b exec %0d want 1001/4", fl_f, ex_f);
        end
        MemWriteE = 1'b0;
    endtask

    task automatic test_stall_flush();
        logic [2:0] mode [4];
        mode[0] = 3'b110; mode[1] = 3'b101; mode[2] = 3'b111; mode[3] = 3'b000;
        for (int i = 0; i < 4; i++) begin
            drive(mode[i][2] | (i == 3 ? 1'b0 : 1'b0), mode[i][1], mode[i][0], 4'b1110, 2'b11, 32'h0, 1, 0);
            n_cmp++;
            if (cx_f !== 1'b0) begin n_bad++; $display("FAIL hold_cx[%0d]: got %b want 0", i, cx_f); end
            tick();
            n_cmp++;
            if (fl_f !== 4'b1001 || ex_f !== 16'd4 || sq_f !== 16'd1) begin
                n_bad++; $display("FAIL hold_state[%0d]: flags %b exec %0d squash %0d want 1001/4/1", i, fl_f, ex_f, sq_f);
            end
        end
        drive(0, 0, 0, 4'b0000, 2'b00, 32'h0, 0, 0);
    endtask

    task automatic test_cond_sweep();
        logic [31:0] res;
        logic [3:0]  f;
        logic        exp_f, exp_m;
        do_reset();
        for (int nz = 0; nz < 3; nz++) begin
            for (int cv = 0; cv < 4; cv++) begin
                res = (nz == 2) ? 32'h8000_0000 : (nz == 1) ? 32'h0 : 32'h1;
                f = {nz[1:0] == 2'd2 ? 2'b10 : nz[1:0] == 2'd1 ? 2'b01 : 2'b00, cv[1:0]};
                drive(1, 0, 0, 4'b1110, 2'b11, res, cv[1], cv[0]);
                tick();
                n_cmp++;
                if (fl_f !== f || fl_m !== f) begin
                    n_bad++; $display("FAIL sweep_setup: full %b min %b want %b", fl_f, fl_m, f);
                end
                for (int cc = 0; cc < 16; cc++) begin
                    drive(1, 0, 0, cc[3:0], 2'b00, 32'h0, 0, 0);
                    exp_f = cond_ref(cc[3:0], f);
                    exp_m = (cc == 0 || cc == 1 || cc == 14) ? exp_f : 1'b0;
                    n_cmp++;
                    if (cx_f !== exp_f || cx_m !== exp_m) begin
                        n_bad++; $display("FAIL sweep cond %b flags %b: full %b min %b want %b/%b", cc[3:0], f, cx_f, cx_m, exp_f, exp_m);
                    end
                end
            end
        end
        drive(0, 0, 0, 4'b0000, 2'b00, 32'h0, 0, 0);
    endtask

    task automatic test_min_squash();
        do_reset();
        drive(1, 0, 0, 4'b1110, 2'b11, 32'h1, 1, 0);
        tick();
        drive(1, 0, 0, 4'b0010, 2'b00, 32'h0, 0, 0);
        tick();
        n_cmp++;
        if (ex_f !== 16'd2 || sq_f !== 16'd0 || ex_m !== 16'd1 || sq_m !== 16'd1) begin
            n_bad++; $display("FAIL min_squash: full %0d/%0d min %0d/%0d want 2/0 1/1", ex_f, sq_f, ex_m, sq_m);
        end
        drive(0, 0, 0, 4'b0000, 2'b00, 32'h0, 0, 0);
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 4'b1110, 2'b00, 32'h0, 0, 0);
            tick();
        end
        n_cmp++;
        if (ex_s !== 4'd15 || ex_f !== 16'd20) begin
            n_bad++; $display("FAIL saturate: sat %0d full %0d want 15/20", ex_s, ex_f);
        end
        for (int i = 0; i < 18; i++) begin
            drive(1, 0, 0, 4'b1111, 2'b00, 32'h0, 0, 0);
            tick();
        end
        n_cmp++;
        if (sq_s !== 4'd15 || sq_f !== 16'd18) begin
            n_bad++; $display("FAIL squash_saturate: sat %0d full %0d want 15/18", sq_s, sq_f);
        end
        reset_n = 1'b0;
        drive(1, 0, 0, 4'b1110, 2'b11, 32'h0, 1, 1);
        tick();
        n_cmp++;
        if (ex_s !== 4'd0 || sq_s !== 4'd0 || fl_s !== 4'b0000 || ex_f !== 16'd0) begin
            n_bad++; $display("FAIL sat_reset: exec %0d squash %0d flags %b full %0d want 0/0/0000/0", ex_s, sq_s, fl_s, ex_f);
        end
        reset_n = 1'b1;
        drive(0, 0, 0, 4'b0000, 2'b00, 32'h0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        PCSrcE = 1'b0; RegWriteE = 1'b0; MemWriteE = 1'b0;
        drive(0, 0, 0, 4'b0000, 2'b00, 32'h0, 0, 0);
        tick();
        test_reset();
        test_post_reset_cond();
        test_back_to_back();
        test_ne_squash();
        test_partial_write();
        test_stall_flush();
        test_cond_sweep();
        test_min_squash();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
